montgomery_mult: RTL



---
 rtl/montgomery_mult_pkg.sv | 14 +
 rtl/montgomery_mult_if.sv | 17 +
 rtl/montgomery_mult_rca.sv | 21 ++
 rtl/montgomery_mult.sv | 102 ++++++++++
 4 files changed

// File: rtl/montgomery_mult_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier: the FSM state
// encoding and the default operand width.
package montgomery_mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD_B = 2'd1,
    ADD_M = 2'd2,
    SUB   = 2'd3
  } state_e;

endpackage

// File: rtl/montgomery_mult_if.sv
// Request/result bundle between the Montgomery multiplier and its requester.
interface montgomery_mult_if
  import montgomery_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] p;

  modport master (output start, a, b, m, input busy, done, p);
  modport slave  (input start, a, b, m, output busy, done, p);
endinterface

// File: rtl/montgomery_mult_rca.sv
// Plain ripple-carry adder, one generated full-adder cell per bit.
module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  logic [WIDTH:0] w_c;

  assign w_c[0] = ci;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign sum[g]   = a[g] ^ b[g] ^ w_c[g];
    assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
  end

  assign co = w_c[WIDTH];
endmodule

// File: rtl/montgomery_mult.sv
// Iterative radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod m in
// 2*WIDTH+1 cycles, sharing one WIDTH+2 bit adder for every addition.
module montgomery_mult
  import montgomery_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  montgomery_mult_if.slave  bus
);
  localparam int AW = WIDTH + 2;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_m, r_p;
  logic [AW-1:0]    r_acc;
  logic [IW-1:0]    r_i;
  logic             r_q, r_busy, r_done;

  logic [AW-1:0]    w_opb, w_sum;
  logic             w_ci, w_co;

  // Second adder operand per state; the accumulator is always the first.
  always_comb begin
    w_opb = '0;
    w_ci  = 1'b0;
    case (r_state)
      ADD_B: if (r_a[r_i]) w_opb = {2'b00, r_b};
      ADD_M: if (r_q)      w_opb = {2'b00, r_m};
      SUB: begin
        w_opb = {2'b11, ~r_m};
        w_ci  = 1'b1;
      end
      default: ;
    endcase
  end

  ripple_carry_adder #(.WIDTH(AW)) u_add (
    .a   (r_acc),
    .b   (w_opb),
    .ci  (w_ci),
    .sum (w_sum),
    .co  (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_m     <= bus.m;
            r_acc   <= '0;
            r_i     <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD_B;
          end
        end
        ADD_B: begin
          r_acc   <= w_sum;
          r_q     <= r_acc[0] ^ (r_a[r_i] & r_b[0]);
          r_state <= ADD_M;
        end
        ADD_M: begin
          // q was chosen so the sum is even; the shift drops a zero bit.
          r_acc <= {1'b0, w_sum[AW-1:1]};
          if (r_i == IW'(WIDTH - 1)) begin
            r_state <= SUB;
          end else begin
            r_i     <= r_i + 1'b1;
            r_state <= ADD_B;
          end
        end
        SUB: begin
          r_p     <= w_co ? w_sum[WIDTH-1:0] : r_acc[WIDTH-1:0];
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.p    = r_p;
endmodule
